// File: rtl/player_sequencer_pkg.sv
// Shared types and constants for the music player sequencer.
// The button order here is also the bit order of the command vector.
package player_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'd0,
    ST_PLAYING = 2'd1,
    ST_LOAD    = 2'd2
  } state_t;

  localparam int SEEK_SHORT = 10;
  localparam int SEEK_LONG  = 30;
  localparam logic [7:0] END_WORD = 8'h00;

  localparam int NUM_BTN = 7;
  localparam int B_PLAY  = 0;
  localparam int B_PROX  = 1;
  localparam int B_PREV  = 2;
  localparam int B_P30   = 3;
  localparam int B_V30   = 4;
  localparam int B_P10   = 5;
  localparam int B_V10   = 6;

  // Seek distance in seconds for the highest-priority seek command present.
  function automatic int seek_seconds(input logic [NUM_BTN-1:0] cmd);
    if (cmd[B_P30])      return SEEK_LONG;
    else if (cmd[B_V30]) return -SEEK_LONG;
    else if (cmd[B_P10]) return SEEK_SHORT;
    else if (cmd[B_V10]) return -SEEK_SHORT;
    else                 return 0;
  endfunction

endpackage

// File: rtl/player_sequencer_button_edge.sv
// One-bit button register with a rising-edge command pulse.
// The pulse is combinational so a command acts in the cycle the level rises.
module button_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic q;

  always_ff @(posedge clk) begin
    if (reset) q <= 1'b0;
    else       q <= btn;
  end

  assign pulse = btn & ~q;

endmodule

// File: rtl/player_sequencer.sv
// Player controller: button edges, navigation arbitration, song/address sequencing.
// LOAD is a single cycle after any song (re)start; it then returns to the state held in play.
module player_sequencer
  import player_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int SEL_W       = 2,
  parameter int SAMPLE_RATE = 8000,
  parameter int RESTART_SEC = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_tick,
  input  logic                btn_play_pause,
  input  logic                btn_prox,
  input  logic                btn_prev,
  input  logic                btn_passa_10s,
  input  logic                btn_volta_10s,
  input  logic                btn_passa_30s,
  input  logic                btn_volta_30s,
  input  logic [7:0]          rom_data,
  output logic [SEL_W-1:0]    select,
  output logic [ADDR_W-1:0]   endereco,
  output logic                play,
  output logic                start,
  output logic signed [8:0]   time_adder
);

  localparam int SW = ADDR_W + 2;
  localparam logic [ADDR_W-1:0] ADDR_MAX     = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] RESTART_ADDR = ADDR_W'(RESTART_SEC * SAMPLE_RATE);

  logic [NUM_BTN-1:0] btn_lvl, cmd;

  assign btn_lvl = {btn_volta_10s, btn_passa_10s, btn_volta_30s, btn_passa_30s,
                    btn_prev, btn_prox, btn_play_pause};

  button_edge u_edge [NUM_BTN-1:0] (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_lvl),
    .pulse (cmd)
  );

  state_t                state, state_n;
  logic                  play_n;
  logic [SEL_W-1:0]      sel_n;
  logic [ADDR_W-1:0]     addr_n;
  logic signed [8:0]     ta_n;

  int                    seek_sec;
  logic                  seek_req, seek_over, eos;
  logic signed [SW-1:0]  seek_sum;

  // Seek target is computed two bits wider and signed so both under- and overflow are visible.
  always_comb begin
    seek_sec  = seek_seconds(cmd);
    seek_req  = |cmd[B_V10:B_P30];
    seek_sum  = $signed({2'b00, endereco}) + $signed(SW'(seek_sec * SAMPLE_RATE));
    seek_over = seek_sum > $signed({2'b00, ADDR_MAX});
    eos       = (state == ST_PLAYING) && sample_tick &&
                ((rom_data == END_WORD) || (endereco == ADDR_MAX));
  end

  always_comb begin
    play_n  = play ^ cmd[B_PLAY];
    state_n = play_n ? ST_PLAYING : ST_PAUSED;
    sel_n   = select;
    addr_n  = endereco;
    ta_n    = '0;
    // Navigation is masked during LOAD so it stays exactly one cycle.
    if (state != ST_LOAD) begin
      if (eos || cmd[B_PROX]) begin
        sel_n   = select + 1'b1;
        addr_n  = '0;
        state_n = ST_LOAD;
      end else if (cmd[B_PREV]) begin
        if (endereco < RESTART_ADDR) sel_n = select - 1'b1;
        addr_n  = '0;
        state_n = ST_LOAD;
      end else if (seek_req) begin
        if (seek_sum[SW-1]) begin
          addr_n  = '0;
          state_n = ST_LOAD;
        end else if (seek_over) begin
          sel_n   = select + 1'b1;
          addr_n  = '0;
          state_n = ST_LOAD;
        end else begin
          addr_n = seek_sum[ADDR_W-1:0];
          ta_n   = 9'(seek_sec);
        end
      end else if ((state == ST_PLAYING) && sample_tick) begin
        addr_n = endereco + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_PAUSED;
      play       <= 1'b0;
      select     <= '0;
      endereco   <= '0;
      time_adder <= '0;
    end else begin
      state      <= state_n;
      play       <= play_n;
      select     <= sel_n;
      endereco   <= addr_n;
      time_adder <= ta_n;
    end
  end

  assign start = (state == ST_LOAD);

endmodule

// File: tb/tb_player_sequencer.sv
// Bench for player_sequencer: vector table, hand sequences for multi-cycle corners,
// then random traffic against a behavioural model of the player.
module tb_player_sequencer;

  localparam int SR    = 4;
  localparam int RSEC  = 3;
  localparam int AW    = 22;
  localparam int MAXA  = (1 << AW) - 1;

  // Bench button vector bits: 0 play_pause, 1 prox, 2 prev, 3 +30, 4 -30, 5 +10, 6 -10
  localparam logic [6:0] PP = 7'b0000001, PX = 7'b0000010, PV = 7'b0000100,
                         P30 = 7'b0001000, V30 = 7'b0010000, P10 = 7'b0100000,
                         V10 = 7'b1000000, NB = 7'b0000000;

  logic clk = 1'b0, reset = 1'b0, sample_tick = 1'b0;
  logic [6:0] b = '0;
  logic [7:0] rom_data;
  logic [1:0] select;
  logic [AW-1:0] endereco;
  logic play, start;
  logic signed [8:0] time_adder;

  int end_addr [4] = '{-1, -1, -1, -1};
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  always_comb begin
    rom_data = 8'h55;
    if (int'(endereco) == end_addr[select]) rom_data = 8'h00;
  end

  player_sequencer #(.ADDR_W(AW), .SEL_W(2), .SAMPLE_RATE(SR), .RESTART_SEC(RSEC)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .btn_play_pause(b[0]), .btn_prox(b[1]), .btn_prev(b[2]),
    .btn_passa_30s(b[3]), .btn_volta_30s(b[4]),
    .btn_passa_10s(b[5]), .btn_volta_10s(b[6]),
    .rom_data(rom_data), .select(select), .endereco(endereco),
    .play(play), .start(start), .time_adder(time_adder)
  );

  // Behavioural model: song number, position in words, play flag, and the one-cycle start/seek outputs.
  int m_sel = 0, m_addr = 0, m_ta = 0;
  bit m_play = 0, m_start = 0;
  logic [6:0] m_lvl = '0;

  task automatic model_step(input logic r, input logic [6:0] btn, input logic tick);
    logic [6:0] rise;
    int secs, tgt;
    bit ns, at_end, n_play, n_start;
    int n_ta;
    if (r) begin
      m_sel = 0; m_addr = 0; m_ta = 0; m_play = 0; m_start = 0; m_lvl = '0;
      return;
    end
    rise    = btn & ~m_lvl;
    m_lvl   = btn;
    n_play  = m_play ^ rise[0];
    n_start = 0;
    n_ta    = 0;
    ns      = 0;
    at_end  = (m_addr == end_addr[m_sel]) || (m_addr == MAXA);
    secs    = rise[3] ? 30 : rise[4] ? -30 : rise[5] ? 10 : rise[6] ? -10 : 0;
    if (!m_start) begin
      if ((m_play && tick && at_end) || rise[1]) ns = 1;
      else if (rise[2]) begin
        if (m_addr < RSEC * SR) m_sel = (m_sel + 3) % 4;
        m_addr = 0; n_start = 1;
      end else if (rise[6:3] != 0) begin
        tgt = m_addr + secs * SR;
        if (tgt < 0) begin m_addr = 0; n_start = 1; end
        else if (tgt > MAXA) ns = 1;
        else begin m_addr = tgt; n_ta = secs; end
      end else if (m_play && tick) m_addr++;
      if (ns) begin m_sel = (m_sel + 1) % 4; m_addr = 0; n_start = 1; end
    end
    m_play = n_play; m_start = n_start; m_ta = n_ta;
  endtask

  task automatic step(input logic r, input logic [6:0] btn, input logic tick);
    reset = r; b = btn; sample_tick = tick;
    @(posedge clk);
    model_step(r, btn, tick);
    #1;
  endtask

  task automatic chk(input string name, input int sel, input int addr, input bit ply,
                     input bit st, input int ta);
    tests++;
    if (int'(select) != sel || int'(endereco) != addr || play !== ply || start !== st ||
        int'(time_adder) != ta) begin
      fails++;
      $display("FAIL %s: got sel=%0d addr=%0d play=%0b start=%0b ta=%0d, want sel=%0d addr=%0d play=%0b start=%0b ta=%0d",
               name, select, endereco, play, start, time_adder, sel, addr, ply, st, ta);
    end
  endtask

  typedef struct {
    logic r; logic [6:0] btn; logic tick;
    int sel; int addr; bit ply; bit st; int ta;
  } vec_t;
  vec_t vt[$];

  function automatic void add(input logic r, input logic [6:0] btn, input logic tick,
                              input int sel, input int addr, input bit ply, input bit st, input int ta);
    vec_t v;
    v.r = r; v.btn = btn; v.tick = tick;
    v.sel = sel; v.addr = addr; v.ply = ply; v.st = st; v.ta = ta;
    vt.push_back(v);
  endfunction

  initial begin
    // Play/pause edge detection, advance, pause hold, seek forward, seek below zero.
    add(1, NB, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, PP, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 6; i++) add(0, NB, 1, 0, i, 1, 0, 0);
    add(0, PP, 0, 0, 6, 0, 0, 0);
    add(0, NB, 1, 0, 6, 0, 0, 0);
    add(0, NB, 1, 0, 6, 0, 0, 0);
    add(0, PP, 0, 0, 6, 1, 0, 0);
    add(0, NB, 0, 0, 6, 1, 0, 0);
    add(0, P10, 0, 0, 46, 1, 0, 10);
    add(0, NB, 0, 0, 46, 1, 0, 0);
    add(0, V30, 0, 0, 0, 1, 1, 0);
    add(0, NB, 0, 0, 0, 1, 0, 0);
    add(0, NB, 1, 0, 1, 1, 0, 0);
    foreach (vt[i]) begin
      step(vt[i].r, vt[i].btn, vt[i].tick);
      chk($sformatf("vec%0d", i), vt[i].sel, vt[i].addr, vt[i].ply, vt[i].st, vt[i].ta);
    end

    // End-of-song marker at {1,20}.
    step(1, NB, 0); step(0, PP, 0); step(0, NB, 0);
    step(0, PX, 0);  chk("s3_prox", 1, 0, 1, 1, 0);
    step(0, NB, 0);  chk("s3_load_end", 1, 0, 1, 0, 0);
    end_addr[1] = 20;
    for (int i = 0; i < 20; i++) step(0, NB, 1);
    chk("s3_at20", 1, 20, 1, 0, 0);
    step(0, NB, 1);  chk("s3_eos", 2, 0, 1, 1, 0);
    step(0, NB, 1);  chk("s3_tick_in_load", 2, 0, 1, 0, 0);
    end_addr[1] = -1;

    // prev: below threshold goes back (wrapping), at threshold restarts.
    step(1, NB, 0); step(0, PP, 0); step(0, NB, 0);
    for (int i = 0; i < 5; i++) step(0, NB, 1);
    step(0, PV, 0);  chk("s4_prev_back", 3, 0, 1, 1, 0);
    step(0, NB, 0);
    for (int i = 0; i < 12; i++) step(0, NB, 1);
    chk("s4_at12", 3, 12, 1, 0, 0);
    step(0, PV, 0);  chk("s4_prev_restart", 3, 0, 1, 1, 0);
    step(0, NB, 0);

    // prox beats a simultaneous seek; select wraps 3 -> 0.
    step(0, PX | P30, 0); chk("s5_prox_wins", 0, 0, 1, 1, 0);
    step(0, NB, 0);       chk("s5_seek_dropped", 0, 0, 1, 0, 0);

    // Reset in the same cycle as a prox edge.
    for (int i = 0; i < 3; i++) step(0, NB, 1);
    step(1, PX, 0);  chk("s6_reset_abort", 0, 0, 0, 0, 0);
    step(0, NB, 0);  chk("s6_after", 0, 0, 0, 0, 0);

    // Seeks while paused, including a negative time_adder.
    step(0, P30, 0); chk("paused_p30", 0, 120, 0, 0, 30);
    step(0, NB, 1);  chk("paused_hold", 0, 120, 0, 0, 0);
    step(0, V10, 0); chk("paused_v10", 0, 80, 0, 0, -10);
    step(0, NB, 0);

    // Random traffic against the model.
    for (int s = 0; s < 4; s++) end_addr[s] = $urandom_range(8, 60);
    step(1, NB, 0);
    begin
      logic [6:0] lvl;
      logic r, t;
      lvl = '0;
      for (int c = 0; c < 4000; c++) begin
        for (int k = 0; k < 7; k++)
          if ($urandom_range(0, 9) == 0) lvl[k] = ~lvl[k];
        r = ($urandom_range(0, 299) == 0);
        t = $urandom_range(0, 1) != 0;
        step(r, lvl, t);
        chk("rand", m_sel, m_addr, m_play, m_start, m_ta);
        if (r) lvl = '0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
